ahb_slave: RTL

AHB_SLAVE -- requirements
Module: ahb_slave

---
 rtl/ahb_pkg.sv | 52 +++++
 rtl/ahb_slave_regfile.sv | 32 +++
 rtl/ahb_slave.sv | 101 ++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, FSM state codes and small decode helpers used by the
// AHB register-file slave.
package ahb_pkg;

    // htrans codes
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // hsize codes
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // hresp codes
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // slave FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    // Address-phase controls held for the following data phase
    typedef struct packed {
        logic        active;   // a valid (non-error) transfer owns this data phase
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
    } dphase_t;

    // Byte lanes touched by a transfer of the given size at the given offset
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] off);
        case (size)
            HSIZE_BYTE: return 4'b0001 << off;
            HSIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    // Out of range, unsupported size, or misaligned for its size
    function automatic logic xfer_error(input logic [31:0] addr, input logic [2:0] size,
                                        input logic [31:0] limit);
        logic misaligned;
        misaligned = ((size == HSIZE_HALF) && addr[0]) ||
                     ((size == HSIZE_WORD) && (addr[1:0] != 2'b00));
        return (addr >= limit) || (size > HSIZE_WORD) || misaligned;
    endfunction

endpackage

// File: rtl/ahb_slave_regfile.sv
// DEPTH x 32 storage with per-byte write enables, synchronous write,
// combinational read and a synchronous clear-to-zero reset.
import ahb_pkg::*;

module ahb_slave_regfile #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Clear every word on reset, otherwise merge enabled byte lanes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave.sv
// AHB-Lite register-file slave: pipelined address/data phases, fixed wait
// states on OKAY transfers, two-cycle ERROR response on bad accesses.
import ahb_pkg::*;

module ahb_slave #(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] LIMIT   = 32'(DEPTH * 4);
    // last value of the wait counter before the completion cycle
    localparam logic [3:0]  WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    dphase_t     dp;
    logic        ready_out;
    logic        accept;
    logic        addr_err;
    logic        complete;
    logic [31:0] rf_rdata;
    logic        unused_ok;

    // Only IDLE and ERR2 end a data phase, so only they may take a new address
    assign ready_out = (state == ST_IDLE) || (state == ST_ERR2);
    assign accept    = hsel && hready && htrans[1] && ready_out;
    assign addr_err  = xfer_error(haddr, hsize, LIMIT);
    assign complete  = (state == ST_IDLE) && dp.active;

    assign hreadyout = ready_out;
    assign hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign hrdata    = (complete && !dp.write) ? rf_rdata : 32'd0;

    // hburst/hprot are accepted but carry no meaning for this slave
    assign unused_ok = ^{hburst, hprot, dp.addr[31:AW+2]};

    // Data-phase FSM: wait-state counting, error sequencing, address capture
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            dp       <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == WS_LAST) begin
                        state    <= ST_IDLE;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_ERR1: state <= ST_ERR2;
                default: begin
                    if (accept) begin
                        dp.write <= hwrite;
                        dp.size  <= hsize;
                        dp.addr  <= haddr;
                        if (addr_err) begin
                            dp.active <= 1'b0;
                            state     <= ST_ERR1;
                        end else begin
                            dp.active <= 1'b1;
                            state     <= (WAIT_STATES > 0) ? ST_WAIT : ST_IDLE;
                        end
                    end else begin
                        dp.active <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    ahb_slave_regfile #(.DEPTH(DEPTH)) u_regfile (
        .clk   (hclk),
        .rst_n (hresetn),
        .we    (complete && dp.write),
        .be    (byte_lanes(dp.size, dp.addr[1:0])),
        .addr  (dp.addr[AW+1:2]),
        .wdata (hwdata),
        .rdata (rf_rdata)
    );

endmodule
